// File: rtl/sdrm_req_seq.sv
// SDRAM request sequencer: runs the power-up command sequence, then feeds single-outstanding
// host reads/writes to the controller, retiring each on ctl_ready or on a timeout.
module sdrm_req_seq #(
   parameter logic [15:0] INIT_CYCLES = 16'd20000,
   parameter logic [3:0]  INIT_REFS   = 4'd2,
   parameter logic [7:0]  TMO_CYCLES  = 8'd255
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        host_req,
   input  logic        host_wr,
   input  logic [19:0] host_addr,
   output logic        host_ack,
   output logic        host_done,
   output logic        host_err,
   output logic        init_done,
   output logic        seq_err,
   output logic [2:0]  Act_st,
   output logic        write_st,
   output logic [19:0] Add_reg,
   input  logic        ctl_ready,
   input  logic        ctl_kid
);

   typedef enum logic [2:0] {
      RST_WAIT, INIT_PRE, INIT_REF, INIT_MRS, IDLE, ACCESS, GAP
   } state_t;

   localparam logic [2:0] CMD_NOP = 3'b000;
   localparam logic [2:0] CMD_PRE = 3'b001;
   localparam logic [2:0] CMD_REF = 3'b010;
   localparam logic [2:0] CMD_MRS = 3'b011;
   localparam logic [2:0] CMD_RD  = 3'b100;
   localparam logic [2:0] CMD_WR  = 3'b101;

   state_t      state_q, state_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic [3:0]  ref_cnt_q, ref_cnt_d;
   logic [7:0]  tmo_cnt_q, tmo_cnt_d;
   logic [2:0]  act_st_q, act_st_d;
   logic        write_st_q, write_st_d;
   logic [19:0] add_reg_q, add_reg_d;
   logic        host_ack_q, host_ack_d;
   logic        host_done_q, host_done_d;
   logic        host_err_q, host_err_d;
   logic        init_done_q, init_done_d;
   logic        seq_err_q, seq_err_d;

   logic cmd_live;
   logic tmo_hit;
   logic cmd_end;

   // A command is only "in flight" while it is actually driven; ready or timeout on NOP is ignored.
   always_comb begin
      cmd_live = (act_st_q != CMD_NOP);
      tmo_hit  = cmd_live && !ctl_ready && (tmo_cnt_q == TMO_CYCLES - 8'd1);
      cmd_end  = cmd_live && (ctl_ready || tmo_hit);
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      ref_cnt_d   = ref_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      act_st_d    = act_st_q;
      write_st_d  = write_st_q;
      add_reg_d   = add_reg_q;
      host_ack_d  = 1'b0;
      host_done_d = 1'b0;
      host_err_d  = 1'b0;
      init_done_d = init_done_q;
      seq_err_d   = seq_err_q | tmo_hit;

      if (cmd_live && !cmd_end) begin
         tmo_cnt_d = tmo_cnt_q + 8'd1;
      end

      case (state_q)
         RST_WAIT: begin
            if (wait_cnt_q == 16'd0) begin
               state_d   = INIT_PRE;
               act_st_d  = CMD_PRE;
               tmo_cnt_d = 8'd0;
            end else begin
               wait_cnt_d = wait_cnt_q - 16'd1;
            end
         end
         INIT_PRE: begin
            if (cmd_end) begin
               state_d  = GAP;
               act_st_d = CMD_NOP;
            end
         end
         INIT_REF: begin
            if (cmd_end) begin
               state_d   = GAP;
               act_st_d  = CMD_NOP;
               ref_cnt_d = ref_cnt_q + 4'd1;
            end
         end
         INIT_MRS: begin
            if (cmd_end) begin
               state_d     = IDLE;
               act_st_d    = CMD_NOP;
               init_done_d = 1'b1;
            end
         end
         // The refresh count alone tells GAP whether more refreshes are owed.
         GAP: begin
            tmo_cnt_d = 8'd0;
            if (ref_cnt_q < INIT_REFS) begin
               state_d  = INIT_REF;
               act_st_d = CMD_REF;
            end else begin
               state_d  = INIT_MRS;
               act_st_d = CMD_MRS;
            end
         end
         IDLE: begin
            if (host_req && !ctl_kid && !host_done_q) begin
               state_d    = ACCESS;
               add_reg_d  = host_addr;
               write_st_d = host_wr;
               host_ack_d = 1'b1;
               tmo_cnt_d  = 8'd0;
            end
         end
         ACCESS: begin
            if (cmd_end) begin
               state_d     = IDLE;
               act_st_d    = CMD_NOP;
               host_done_d = 1'b1;
               host_err_d  = tmo_hit;
            end else begin
               act_st_d = write_st_q ? CMD_WR : CMD_RD;
            end
         end
         default: begin
            state_d  = RST_WAIT;
            act_st_d = CMD_NOP;
         end
      endcase
   end

   // The wait counter is preloaded during reset so the first command lands exactly INIT_CYCLES later.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= RST_WAIT;
         wait_cnt_q  <= INIT_CYCLES - 16'd1;
         ref_cnt_q   <= 4'd0;
         tmo_cnt_q   <= 8'd0;
         act_st_q    <= CMD_NOP;
         write_st_q  <= 1'b0;
         add_reg_q   <= 20'd0;
         host_ack_q  <= 1'b0;
         host_done_q <= 1'b0;
         host_err_q  <= 1'b0;
         init_done_q <= 1'b0;
         seq_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         ref_cnt_q   <= ref_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         act_st_q    <= act_st_d;
         write_st_q  <= write_st_d;
         add_reg_q   <= add_reg_d;
         host_ack_q  <= host_ack_d;
         host_done_q <= host_done_d;
         host_err_q  <= host_err_d;
         init_done_q <= init_done_d;
         seq_err_q   <= seq_err_d;
      end
   end

   assign Act_st    = act_st_q;
   assign write_st  = write_st_q;
   assign Add_reg   = add_reg_q;
   assign host_ack  = host_ack_q;
   assign host_done = host_done_q;
   assign host_err  = host_err_q;
   assign init_done = init_done_q;
   assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_sdrm_req_seq.sv
// Randomized scoreboard bench for sdrm_req_seq with a behavioural controller model.
module tb_sdrm_req_seq;
   localparam int ICYC  = 10;
   localparam int IREFS = 2;
   localparam int TMO   = 5;
   localparam int CDLY  = 3;

   logic        Clk;
   logic        Reset = 1'b1;
   logic        host_req = 1'b0;
   logic        host_wr = 1'b0;
   logic [19:0] host_addr = 20'd0;
   logic        host_ack, host_done, host_err, init_done, seq_err, write_st;
   logic [2:0]  Act_st;
   logic [19:0] Add_reg;
   logic        ctl_ready = 1'b0;
   logic        ctl_kid = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_done_cyc = -100;
   bit sticky = 1'b0;
   bit spur = 1'b0;

   typedef struct {
      logic [19:0] addr;
      logic        wr;
      bit          err;
      int          dur;
   } exp_t;
   typedef struct {
      int dly;
      bit mute;
   } ctl_t;

   exp_t exp_q[$];
   ctl_t ctl_q[$];

   sdrm_req_seq #(
      .INIT_CYCLES(16'(ICYC)),
      .INIT_REFS  (4'(IREFS)),
      .TMO_CYCLES (8'(TMO))
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .host_req (host_req),
      .host_wr  (host_wr),
      .host_addr(host_addr),
      .host_ack (host_ack),
      .host_done(host_done),
      .host_err (host_err),
      .init_done(init_done),
      .seq_err  (seq_err),
      .Act_st   (Act_st),
      .write_st (write_st),
      .Add_reg  (Add_reg),
      .ctl_ready(ctl_ready),
      .ctl_kid  (ctl_kid)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial forever begin
      @(posedge Clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: sim time expired, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input bit ok, input string nm, input int act, input int exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // Controller: answers each driven command after a per-command delay, or never when muted.
   initial begin : ctl_model
      int   live;
      ctl_t cur;
      live     = 0;
      cur.dly  = CDLY;
      cur.mute = 1'b0;
      forever begin
         @(posedge Clk);
         #2;
         ctl_ready = spur;
         if (Reset || Act_st == 3'b000) begin
            live = 0;
         end else begin
            if (live == 0) begin
               if (init_done && ctl_q.size() > 0) begin
                  cur = ctl_q.pop_front();
               end else begin
                  cur.dly  = CDLY;
                  cur.mute = 1'b0;
               end
            end
            live++;
            if (!cur.mute && live == cur.dly) ctl_ready = 1'b1;
         end
      end
   end

   initial begin : monitor
      int   run;
      exp_t e;
      run = 0;
      forever begin
         @(negedge Clk);
         if (Reset) begin
            run = 0;
         end else begin
            if (host_ack) begin
               if (exp_q.size() == 0) begin
                  chk(1'b0, "ack_unexpected", 1, 0);
               end else begin
                  chk(Add_reg == exp_q[0].addr, "ack_addr", int'(Add_reg), int'(exp_q[0].addr));
                  chk(write_st == exp_q[0].wr, "ack_wr", int'(write_st), int'(exp_q[0].wr));
               end
            end
            if (init_done && Act_st != 3'b000) begin
               if (run == 0 && exp_q.size() > 0)
                  chk(Act_st == (exp_q[0].wr ? 3'b101 : 3'b100), "cmd_code", int'(Act_st),
                      exp_q[0].wr ? 5 : 4);
               run++;
            end
            if (host_done) begin
               if (exp_q.size() == 0) begin
                  chk(1'b0, "done_unexpected", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  if (e.err) sticky = 1'b1;
                  chk(host_err == e.err, "done_err", int'(host_err), int'(e.err));
                  chk(run == e.dur, "cmd_len", run, e.dur);
                  chk(seq_err == sticky, "seq_err", int'(seq_err), int'(sticky));
                  chk(Add_reg == e.addr, "addr_hold", int'(Add_reg), int'(e.addr));
               end
               run = 0;
               last_done_cyc = cyc;
            end
         end
      end
   end

   task automatic chk_rst_vals(input string nm);
      chk({Act_st, write_st, Add_reg, host_ack, host_done, host_err, init_done, seq_err} == 29'd0,
          nm, int'({Act_st, write_st, Add_reg, host_ack, host_done, host_err, init_done, seq_err}), 0);
   endtask

   // Called in the first cycle with Reset low; walks the expected per-cycle command trace.
   task automatic check_init();
      int  seq[$];
      int  cmds[$];
      int  errs;
      int  first_bad;
      bit  ed;
      for (int k = 0; k < ICYC; k++) seq.push_back(0);
      cmds.push_back(1);
      for (int k = 0; k < IREFS; k++) cmds.push_back(2);
      cmds.push_back(3);
      foreach (cmds[j]) begin
         for (int k = 0; k < CDLY; k++) seq.push_back(cmds[j]);
         seq.push_back(0);
      end
      errs = 0;
      first_bad = -1;
      for (int k = 0; k < seq.size(); k++) begin
         ed = (k == seq.size() - 1);
         if (Act_st !== 3'(seq[k]) || init_done !== ed) begin
            errs++;
            if (first_bad < 0) first_bad = k;
         end
         if (k < seq.size() - 1) begin
            @(posedge Clk);
            #1;
         end
      end
      chk(errs == 0, "init_seq_first_bad_cycle", first_bad, -1);
   endtask

   task automatic xact(input logic [19:0] a, input logic w, input int dly, input bit mute,
                       input int kid_n);
      exp_t e;
      ctl_t c;
      int   r, got, want;
      e.addr = a;
      e.wr   = w;
      e.err  = mute;
      e.dur  = mute ? TMO : dly;
      c.dly  = dly;
      c.mute = mute;
      exp_q.push_back(e);
      ctl_q.push_back(c);
      r = cyc;
      host_req  = 1'b1;
      host_wr   = w;
      host_addr = a;
      ctl_kid   = (kid_n > 0);
      got = -1;
      for (int k = 0; k < 200; k++) begin
         @(posedge Clk);
         #1;
         ctl_kid = (cyc < r + kid_n);
         if (host_ack) begin
            got = cyc;
            break;
         end
      end
      host_req = 1'b0;
      ctl_kid  = 1'b0;
      want = r + kid_n + 1;
      if (last_done_cyc + 2 > want) want = last_done_cyc + 2;
      chk(got == want, "ack_cycle", got, want);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() > 0 && k < 100) begin
         @(posedge Clk);
         #1;
         k++;
      end
      chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
   endtask

   initial begin : driver
      repeat (3) @(posedge Clk);
      #1;
      Reset = 1'b0;
      chk_rst_vals("reset_vals");
      check_init();

      xact(20'hABCDE, 1'b0, 3, 1'b0, 0);
      xact(20'h12345, 1'b1, 2, 1'b0, 8);
      xact(20'h0F0F0, 1'b1, 4, 1'b1, 0);
      xact(20'h55555, 1'b0, TMO, 1'b0, 0);
      xact(20'hAAAAA, 1'b1, 1, 1'b0, 0);
      drain();

      spur = 1'b1;
      @(posedge Clk);
      #1;
      spur = 1'b0;
      chk(host_done == 1'b0 && Act_st == 3'b000 && init_done == 1'b1, "idle_ready_ignored",
          int'({host_done, Act_st, init_done}), 1);

      for (int i = 0; i < 40; i++) begin
         xact(20'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, TMO),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
      end
      drain();

      xact(20'h3C3C3, 1'b1, 1, 1'b1, 0);
      repeat (2) @(posedge Clk);
      #1;
      chk(Act_st == 3'b101, "pre_reset_cmd", int'(Act_st), 5);
      exp_q.delete();
      ctl_q.delete();
      sticky = 1'b0;
      last_done_cyc = -100;
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      chk_rst_vals("reset_mid_access");
      check_init();
      xact(20'h00F00, 1'b0, 2, 1'b0, 0);
      drain();
      repeat (4) @(posedge Clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
